// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction queue.
// Circular buffer of DEPTH {inst, pc} entries between IF and ID. Decode sees
// the head entry combinationally from registered state; fetch sees full as
// pc_stall. flush discards queued and incoming entries; rst overrides all.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   if_inst   tagged instruction from fetch ([34:32] tag, [31:0] word)
//   if_pc     PC of if_inst
//   if_valid  if_inst/if_pc valid this cycle
//   flush     redirect: drop all queued and incoming entries
//   id_stall  decode cannot accept this cycle
//   id_inst   head instruction, NOP_INST when empty
//   id_pc     head PC, 0 when empty
//   id_valid  head entry present
//   pc_stall  queue full, backpressure to fetch
//   count     current occupancy
module if_id_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [34:0] NOP_INST = {3'b000, 32'h00000013}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [34:0]             if_inst,
  input  logic [31:0]             if_pc,
  input  logic                    if_valid,
  input  logic                    flush,
  input  logic                    id_stall,
  output logic [34:0]             id_inst,
  output logic [31:0]             id_pc,
  output logic                    id_valid,
  output logic                    pc_stall,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned INST_W  = 35;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned ENTRY_W = INST_W + PC_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] head;

  // Status derived from registered occupancy only, so full blocks enqueue
  // even when a dequeue happens in the same cycle.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign enq   = if_valid & ~full & ~flush;
  assign deq   = ~empty & ~id_stall & ~flush;

  // Next-state for pointers and occupancy; pointers wrap naturally since
  // DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care once pointers are cleared.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {if_inst, if_pc};
  end

  assign head     = mem_q[rd_ptr_q];
  assign id_valid = ~empty;
  assign pc_stall = full;
  assign count    = count_q;
  assign id_inst  = empty ? NOP_INST : head[ENTRY_W-1:PC_W];
  assign id_pc    = empty ? 32'h0 : head[PC_W-1:0];

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: table of {inputs, expected after-edge outputs}
// plus a queue scoreboard holding every accepted entry in FIFO order.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [34:0] NOP   = {3'b000, 32'h00000013};

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        flush;
  logic        id_stall;
  logic [34:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        pc_stall;
  logic [2:0]  count;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc),
    .if_valid(if_valid), .flush(flush), .id_stall(id_stall),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
    .pc_stall(pc_stall), .count(count)
  );

  typedef struct packed {
    logic [34:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        r, f, v, s;
    logic [31:0] pc;
    int unsigned exp_cnt;
    logic        exp_valid;
    logic        exp_pstall;
    logic [31:0] exp_pc;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [34:0] mk_inst(input logic [31:0] pc);
    logic [2:0] t;
    t = pc[4:2];
    return {t, pc ^ 32'h5A5A0013};
  endfunction

  function automatic void add(input logic r, f, v, s, input logic [31:0] pc,
                              input int unsigned c, input logic val, ps,
                              input logic [31:0] hpc);
    vec_t x;
    x.r = r; x.f = f; x.v = v; x.s = s; x.pc = pc;
    x.exp_cnt = c; x.exp_valid = val; x.exp_pstall = ps; x.exp_pc = hpc;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard comparison: head and status follow the model queue.
  task automatic check_sb();
    logic [34:0] ei;
    logic [31:0] ep;
    ei = (sb.size() != 0) ? sb[0].inst : NOP;
    ep = (sb.size() != 0) ? sb[0].pc   : 32'h0;
    chk("sb_count",    67'(count),    67'(sb.size()));
    chk("sb_id_valid", 67'(id_valid), 67'(sb.size() != 0));
    chk("sb_pc_stall", 67'(pc_stall), 67'(sb.size() == DEPTH));
    chk("sb_id_inst",  67'(id_inst),  67'(ei));
    chk("sb_id_pc",    67'(id_pc),    67'(ep));
  endtask

  // Drive one cycle from the negedge, update the model, check after the edge.
  task automatic drive(input logic r, f, v, s, input logic [31:0] pc,
                       input logic [34:0] inst);
    logic d, e;
    rst = r; flush = f; if_valid = v; id_stall = s; if_pc = pc; if_inst = inst;
    if (r || f) begin
      sb.delete();
    end else begin
      d = (sb.size() != 0) && !s;
      e = v && (sb.size() != DEPTH);
      if (d) void'(sb.pop_front());
      if (e) sb.push_back({inst, pc});
    end
    @(posedge clk);
    @(negedge clk);
    check_sb();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_stall = 1'b0;
    if_pc = '0; if_inst = '0;

    // reset
    add(1,0,0,0,0,   0,0,0,0);
    // fill to full with decode stalled; pc 16 refused
    add(0,0,1,1,0,   1,1,0,0);
    add(0,0,1,1,4,   2,1,0,0);
    add(0,0,1,1,8,   3,1,0,0);
    add(0,0,1,1,12,  4,1,1,0);
    add(0,0,1,1,16,  4,1,1,0);
    // drain in order
    add(0,0,0,0,0,   3,1,0,4);
    add(0,0,0,0,0,   2,1,0,8);
    add(0,0,0,0,0,   1,1,0,12);
    add(0,0,0,0,0,   0,0,0,0);
    // stall on empty queue does nothing
    add(0,0,0,1,0,   0,0,0,0);
    // streaming wrap-around
    for (int i = 0; i < 10; i++) add(0,0,1,0,32'(4*i), 1,1,0,32'(4*i));
    add(0,0,0,0,0,   0,0,0,0);
    // flush with concurrent enqueue
    add(0,0,1,1,100, 1,1,0,100);
    add(0,0,1,1,104, 2,1,0,100);
    add(0,0,1,1,108, 3,1,0,100);
    add(0,1,1,0,112, 0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0);
    // reset beats flush
    add(0,0,1,1,200, 1,1,0,200);
    add(0,0,1,1,204, 2,1,0,200);
    add(1,1,1,0,208, 0,0,0,0);
    // full with simultaneous dequeue
    add(0,0,1,1,300, 1,1,0,300);
    add(0,0,1,1,304, 2,1,0,300);
    add(0,0,1,1,308, 3,1,0,300);
    add(0,0,1,1,312, 4,1,1,300);
    add(0,0,1,0,316, 3,1,0,304);
    add(0,0,1,1,316, 4,1,1,304);
    add(0,0,0,0,0,   3,1,0,308);
    add(0,0,0,0,0,   2,1,0,312);
    add(0,0,0,0,0,   1,1,0,316);
    add(0,0,0,0,0,   0,0,0,0);
    // enq and deq together at count 1
    add(0,0,1,1,400, 1,1,0,400);
    add(0,0,1,0,404, 1,1,0,404);
    add(0,0,0,0,0,   0,0,0,0);
    // flush overrides stall
    add(0,0,1,1,500, 1,1,0,500);
    add(0,1,0,1,0,   0,0,0,0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].s, vecs[i].pc, mk_inst(vecs[i].pc));
      chk($sformatf("tbl%0d_count", i),    67'(count),    67'(vecs[i].exp_cnt));
      chk($sformatf("tbl%0d_id_valid", i), 67'(id_valid), 67'(vecs[i].exp_valid));
      chk($sformatf("tbl%0d_pc_stall", i), 67'(pc_stall), 67'(vecs[i].exp_pstall));
      chk($sformatf("tbl%0d_id_pc", i),    67'(id_pc),    67'(vecs[i].exp_pc));
    end

    // Reset then single enqueue with a tagged instruction.
    drive(1,0,0,0,32'h0,35'h0);
    chk("rst_id_inst", 67'(id_inst), 67'(NOP));
    drive(0,0,1,0,32'h0,{3'b100, 32'h00412083});
    chk("single_valid", 67'(id_valid), 67'(1'b1));
    chk("single_inst",  67'(id_inst),  67'(35'h400412083));
    chk("single_pc",    67'(id_pc),    67'(32'h0));
    drive(0,0,0,0,32'h0,35'h0);
    chk("single_gone_valid", 67'(id_valid), 67'(1'b0));
    chk("single_gone_inst",  67'(id_inst),  67'(NOP));

    // Random mix against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      drive(($urandom_range(0,60) == 0), ($urandom_range(0,15) == 0),
            1'($urandom_range(0,1)), ($urandom_range(0,2) == 0),
            rpc, mk_inst(rpc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter NOP_INST, default {3'b000, 32'h00000013}, 35-bit tagged bubble presented when the queue is empty.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 if_inst  input  35  fetched tagged instruction: [34:32] expansion tag, [31:0] instruction word.
REQ-006 if_pc  input  32  PC of if_inst.
REQ-007 if_valid  input  1  if_inst/if_pc are valid this cycle.
REQ-008 flush  input  1  redirect (branch taken); discards all queued and incoming entries.
REQ-009 id_stall  input  1  decode cannot accept this cycle.
REQ-010 id_inst  output  35  head-entry instruction, or NOP_INST when empty.
REQ-011 id_pc  output  32  head-entry PC, or 32'h0 when empty.
REQ-012 id_valid  output  1  head entry present.
REQ-013 pc_stall  output  1  backpressure to fetch; queue full.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries of {inst[34:0], pc[31:0]} with write pointer, read pointer and occupancy counter.
REQ-016 enq = if_valid & ~pc_stall & ~flush; deq = id_valid & ~id_stall & ~flush.
REQ-017 pc_stall SHALL equal (count == DEPTH), combinational from registered state only; no same-cycle enqueue when full, even if deq is also true.
REQ-018 id_valid SHALL equal (count != 0); id_inst/id_pc SHALL be read combinationally from the entry at the read pointer.
REQ-019 Latency: an entry enqueued at edge N SHALL appear on id_inst/id_pc no earlier than after edge N (one cycle fall-through minimum); no combinational path from if_* to id_*.
REQ-020 Order SHALL be strict FIFO; the 3-bit tag SHALL pass through unmodified.
REQ-021 On enq, write pointer SHALL advance modulo DEPTH; on deq, read pointer SHALL advance modulo DEPTH; both wrap from DEPTH-1 to 0.
REQ-022 count update: enq & ~deq -> +1; deq & ~enq -> -1; both or neither -> unchanged.
REQ-023 Simultaneous enq and deq at count==1 SHALL leave count 1 with the new entry at head after the edge.
REQ-024 flush SHALL, at the next edge, set both pointers and count to 0; the incoming if_inst in that cycle SHALL be discarded; storage contents need not be cleared.
REQ-025 flush SHALL take priority over enq, deq and id_stall.
REQ-026 id_stall with id_valid=0 SHALL have no effect.
REQ-027 Counter SHALL never exceed DEPTH nor go below 0 under any input combination.

Reset
REQ-028 rst SHALL take priority over flush and all other inputs.
REQ-029 After the rst edge: pointers 0, count 0, id_valid 0, pc_stall 0, id_inst = NOP_INST, id_pc = 32'h0.
REQ-030 rst asserted mid-operation SHALL discard all entries in the same edge; storage contents need not be cleared.

Verification
REQ-031 Reset then single enqueue: rst 1 cycle; if_inst={3'b100,32'h00412083}, if_pc=32'h0, if_valid=1 for 1 cycle, id_stall=0 -> next cycle id_valid=1, id_inst=35'h400412083, id_pc=0; following cycle id_valid=0, id_inst=NOP_INST.
REQ-032 Fill to full: id_stall=1, if_valid=1 with pc 0,4,8,12,16 -> pc_stall=1 after 4th edge, count=4; pc 16 not accepted; releasing id_stall drains pc 0,4,8,12 in order, one per cycle.
REQ-033 Wrap-around: continuous if_valid=1, id_stall=0 for 10 cycles with pc 0..36 step 4 -> id_pc sequence 0..36 with no gaps, count stays 1, pointers wrap past 3.
REQ-034 Flush with concurrent enqueue: count=3, flush=1 and if_valid=1 same cycle -> next cycle count=0, id_valid=0, pc_stall=0; incoming entry absent.
REQ-035 Reset beats flush: count=2, rst=1 and flush=1 and if_valid=1 -> next cycle all outputs at REQ-029 values.
REQ-036 Full with simultaneous dequeue: count=4, id_stall=0, if_valid=1 -> count=3 after edge, input not accepted; next cycle input accepted, count returns to 4.
